// File: rtl/spi_slave_rx_if.sv
// Pin-side and local-side signals of the SPI receive endpoint.
// The slave modport is the endpoint's view; master is the driver/consumer view.
interface spi_slave_rx_if #(
  parameter int M = 12
);
  logic         LOAD;
  logic         SCLK;
  logic         MOSI;
  logic         MISO;
  logic [M-1:0] tx_di;
  logic         tx_we;
  logic [M-1:0] DO;
  logic         rx_valid;
  logic         frame_err;
  logic         busy;
  logic [7:0]   cb_bit;
  logic         state_dbg;

  // rx_valid and frame_err are single-cycle strobes with no back-pressure:
  // the consumer must take DO in the cycle rx_valid is high.
  modport slave (
    input  LOAD, SCLK, MOSI, tx_di, tx_we,
    output MISO, DO, rx_valid, frame_err, busy, cb_bit, state_dbg
  );

  modport master (
    output LOAD, SCLK, MOSI, tx_di, tx_we,
    input  MISO, DO, rx_valid, frame_err, busy, cb_bit, state_dbg
  );
endinterface

// File: rtl/spi_slave_rx.sv
// Oversampling SPI slave: shifts MOSI in MSB-first, shifts a held reply word
// out on MISO, and reports each frame as a valid word or a bit-count error.
module spi_slave_rx #(
  parameter int M     = 12,
  parameter int NSYNC = 2
) (
  input  logic           clk,
  input  logic           clr_n,
  spi_slave_rx_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t           state;
  logic [NSYNC-1:0] load_sync;
  logic [NSYNC-1:0] sclk_sync;
  logic [NSYNC-1:0] mosi_sync;
  logic             load_d;
  logic             sclk_d;
  logic             load_s;
  logic             sclk_s;
  logic             mosi_s;
  logic             load_fall;
  logic             load_rise;
  logic             sclk_rise;
  logic             sclk_fall;

  logic [M-1:0]     tx_hold;
  logic [M-1:0]     sr_stx;
  logic [M-1:0]     sr_srx;
  logic [M-1:0]     do_word;
  logic             miso;
  logic             rx_valid;
  logic             frame_err;
  logic             busy;
  logic [7:0]       cb_bit;

  logic [7:0]       cb_next;
  logic [M-1:0]     srx_next;

  assign load_s = load_sync[NSYNC-1];
  assign sclk_s = sclk_sync[NSYNC-1];
  assign mosi_s = mosi_sync[NSYNC-1];

  assign load_fall = load_d & ~load_s;
  assign load_rise = ~load_d & load_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  // The shift is resolved before the end-of-frame test so a rise that lands
  // in the same cycle as the LOAD rise is still counted.
  always_comb begin
    cb_next  = cb_bit;
    srx_next = sr_srx;
    if (sclk_rise) begin
      srx_next = {sr_srx[M-2:0], mosi_s};
      if (cb_bit != 8'hFF) cb_next = cb_bit + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      load_sync <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      load_d    <= 1'b1;
      sclk_d    <= 1'b0;
      state     <= IDLE;
      tx_hold   <= '0;
      sr_stx    <= '0;
      sr_srx    <= '0;
      do_word   <= '0;
      miso      <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      cb_bit    <= '0;
    end else begin
      load_sync <= {load_sync[NSYNC-2:0], bus.LOAD};
      sclk_sync <= {sclk_sync[NSYNC-2:0], bus.SCLK};
      mosi_sync <= {mosi_sync[NSYNC-2:0], bus.MOSI};
      load_d    <= load_s;
      sclk_d    <= sclk_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (bus.tx_we) tx_hold <= bus.tx_di;

      case (state)
        IDLE: begin
          // Keep the first reply bit on MISO before the master starts clocking.
          sr_stx <= tx_hold;
          miso   <= tx_hold[M-1];
          if (load_fall) begin
            state  <= ACTIVE;
            busy   <= 1'b1;
            cb_bit <= '0;
            sr_srx <= '0;
          end
        end
        ACTIVE: begin
          cb_bit <= cb_next;
          sr_srx <= srx_next;
          if (sclk_fall) begin
            sr_stx <= {sr_stx[M-2:0], 1'b0};
            miso   <= sr_stx[M-2];
          end
          if (load_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (cb_next == 8'(M)) begin
              do_word  <= srx_next;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.MISO      = miso;
  assign bus.DO        = do_word;
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err;
  assign bus.busy      = busy;
  assign bus.cb_bit    = cb_bit;
  assign bus.state_dbg = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized bench for spi_slave_rx: frames are modelled as bit lists with an
// expected-word queue, reply-word snapshots and pulse counts.
module tb_spi_slave_rx;
  localparam int M = 12;

  logic clk = 1'b0;
  logic clr_n = 1'b0;

  spi_slave_rx_if #(.M(M)) bus ();

  spi_slave_rx #(.M(M), .NSYNC(2)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [M-1:0] exp_q[$];
  logic [M-1:0] tx_model  = '0;
  logic [M-1:0] last_good = '0;
  int           exp_rx    = 0;
  int           exp_err   = 0;
  int           rx_cnt    = 0;
  int           err_cnt   = 0;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (clr_n) begin
      if (bus.rx_valid) begin
        rx_cnt++;
        check("rx_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("do_word", 32'(bus.DO), 32'(exp_q.pop_front()));
      end
      if (bus.frame_err) err_cnt++;
      if (bus.rx_valid || bus.frame_err)
        check("pulse_excl", 32'(bus.rx_valid & bus.frame_err), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [M-1:0] v);
    bus.tx_di = v;
    bus.tx_we = 1'b1;
    @(negedge clk);
    bus.tx_we = 1'b0;
    tx_model = v;
  endtask

  task automatic send_frame(input logic [M-1:0] word, input int nbits, input int half,
                            input logic do_mid_tx, input logic [M-1:0] mid_tx,
                            input logic check_latency);
    logic [M-1:0] exp_tx;
    logic         exp_bit;
    int           exp_cb;
    exp_tx = tx_model;
    bus.LOAD = 1'b0;
    wait_clk(half);
    check("busy_active", 32'(bus.busy), 32'd1);
    for (int k = 0; k < nbits; k++) begin
      bus.MOSI = (k < M) ? word[M-1-k] : 1'($urandom_range(0, 1));
      if (do_mid_tx && k == 6) write_tx(mid_tx);
      wait_clk(half);
      exp_bit = (k < M) ? exp_tx[M-1-k] : 1'b0;
      check("miso_bit", 32'(bus.MISO), 32'(exp_bit));
      bus.SCLK = 1'b1;
      wait_clk(half);
      bus.SCLK = 1'b0;
    end
    wait_clk(half);
    exp_cb = (nbits > 255) ? 255 : nbits;
    check("cb_bit", 32'(bus.cb_bit), 32'(exp_cb));
    if (nbits == M) begin
      exp_q.push_back(word);
      last_good = word;
      exp_rx++;
    end else begin
      exp_err++;
    end
    bus.LOAD = 1'b1;
    if (check_latency) begin
      wait_clk(2);
      check("rx_early", 32'(bus.rx_valid), 32'd0);
      wait_clk(1);
      check("rx_at_3clk", 32'(bus.rx_valid), 32'(nbits == M));
      wait_clk(1);
      check("rx_one_cycle", 32'(bus.rx_valid), 32'd0);
    end else begin
      wait_clk(4);
    end
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("do_hold", 32'(bus.DO), 32'(last_good));
  endtask

  task automatic reset_mid_frame(input int half);
    int rx0;
    int err0;
    rx0  = rx_cnt;
    err0 = err_cnt;
    bus.LOAD = 1'b0;
    wait_clk(half);
    for (int k = 0; k < 5; k++) begin
      bus.MOSI = 1'($urandom_range(0, 1));
      wait_clk(half);
      bus.SCLK = 1'b1;
      wait_clk(half);
      bus.SCLK = 1'b0;
    end
    clr_n    = 1'b0;
    bus.LOAD = 1'b1;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    wait_clk(3);
    clr_n = 1'b1;
    tx_model  = '0;
    last_good = '0;
    wait_clk(6);
    check("abort_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("abort_no_err", 32'(err_cnt - err0), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_do", 32'(bus.DO), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [M-1:0] w;
    int           nb;
    bus.LOAD  = 1'b1;
    bus.SCLK  = 1'b0;
    bus.MOSI  = 1'b0;
    bus.tx_di = '0;
    bus.tx_we = 1'b0;
    clr_n     = 1'b0;
    wait_clk(3);
    check("rst_do", 32'(bus.DO), 32'd0);
    check("rst_miso", 32'(bus.MISO), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_cb_bit", 32'(bus.cb_bit), 32'd0);
    clr_n = 1'b1;
    wait_clk(4);

    // nominal receive, slow clock
    send_frame(12'hA5C, M, 50, 1'b0, '0, 1'b1);

    // nominal reply word
    write_tx(12'h3C1);
    wait_clk(5);
    send_frame(12'(($urandom)), M, 8, 1'b0, '0, 1'b1);

    // short frame
    send_frame(12'h123, 7, 6, 1'b0, '0, 1'b1);

    // reset in the middle of a frame, then a good one
    reset_mid_frame(6);
    send_frame(12'h0FF, M, 6, 1'b0, '0, 1'b1);

    // back-to-back frames with a reply update during the first
    write_tx(12'h5A5);
    wait_clk(5);
    send_frame(12'h001, M, 6, 1'b1, 12'hC3C, 1'b0);
    send_frame(12'hFFF, M, 6, 1'b0, '0, 1'b0);

    // randomized frames, including short and over-long ones
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        write_tx(12'($urandom));
        wait_clk(5);
      end
      w  = 12'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : M;
      send_frame(w, nb, int'($urandom_range(4, 12)), 1'b0, '0, 1'($urandom_range(0, 1)));
    end

    wait_clk(5);
    check("pending_exp", 32'(exp_q.size()), 32'd0);
    check("rx_count", 32'(rx_cnt), 32'(exp_rx));
    check("err_count", 32'(err_cnt), 32'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
